multi_op_calculator: RTL
========================

Name: multi_op_calculator

Overview:
Parametrised successor to the board-level adder calculator. Operands come from the switches. The block supports add, subtract, multiply and clear, with sign and overflow handling. Binary-to-BCD conversion is a sequential shift-add-3 engine instead of a combinational loop. Output drives a DIGITS-wide multiplexed 7-segment display and LEDs; the block sits directly under the FPGA top level.

Parameters:
WIDTH, 10, operand width in bits (switch count)
DIGITS, 4, number of 7-segment digits (2..8)
REFRESH_DIV, 50000, clk cycles per digit-scan step
DEBOUNCE_CYCLES, 65536, cycles a button must be stable before it is accepted

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
bin  in  WIDTH  switch operand input
btn_save  in  1  latch operand A
btn_exec  in  1  execute op_sel on A and current bin
op_sel  in  2  00 add, 01 subtract (A-B), 10 multiply, 11 clear
seg  out  7  segments A-G, active-low
an  out  DIGITS  digit enables, active-low, one-hot-zero
led  out  WIDTH  mirrors bin, registered
busy  out  1  BCD conversion in progress
overflow  out  1  result magnitude exceeds 10^DIGITS-1
neg  out  1  last result negative

Behaviour:
- Reset (rst=1 at posedge clk) values:
  - Outputs: seg=7'h7F, an all 1, led=0, busy=0, overflow=0, neg=0.
  - Internals: A=0, result=0, state IDLE, scan index 0, digits 0.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a stable counter.
  - A press is accepted as a one-cycle pulse when the debounced level rises.
  - A held button produces exactly one pulse.
- Pulse priority: btn_save and btn_exec pulses in the same cycle: btn_save wins, btn_exec is ignored.
- Operand/result FSM states: IDLE, HAVE_A, SHOW_RES.
  - IDLE: save -> A<=bin, go HAVE_A. exec ignored.
  - HAVE_A: save -> reload A. exec with op_sel 00/01/10 -> compute, go SHOW_RES. exec with op_sel 11 -> go IDLE.
  - SHOW_RES: save -> A<=bin, go HAVE_A. exec with 11 -> IDLE. Other exec -> recompute with same A and the new bin.
- Arithmetic:
  - Result register width is RW=2*WIDTH.
  - Add: A+B, zero-extended.
  - Subtract: if B>A then magnitude B-A and neg=1; else A-B and neg=0.
  - Multiply: A*B, unsigned.
  - neg is cleared on any non-subtract op and on clear.
- Display value: result magnitude in SHOW_RES; bin otherwise, with neg forced to 0.
- BCD engine:
  - Starts when the display value differs from the last converted value and the engine is idle.
  - Cycle 0 loads the value. Then RW cycles of add-3 (each nibble >=5) followed by shift-left-1.
  - Total RW+1 cycles; busy is high for exactly those cycles.
  - Displayed digits update only on completion, so no partial values are ever shown.
  - A change of input during conversion is picked up by the next conversion after completion.
- Overflow:
  - Set at conversion completion if any BCD digit above DIGITS-1 is nonzero.
  - While set, all digits show a dash (7'b0111111).
- Sign: when neg=1 and no overflow, the most significant digit shows a dash. If that digit position holds a nonzero BCD value, overflow=1 instead.
- Scan:
  - Counter counts 0..REFRESH_DIV-1, then the scan index increments, wrapping DIGITS-1 -> 0.
  - Each scan step drives one an bit low, digit 0 = ones at an[0].
  - seg and an are registered and change in the same cycle.
- Decoder: 0-9 use standard active-low patterns; any other value is blank (7'h7F).
- led <= bin every cycle (1-cycle latency).
- Reset mid-conversion aborts the conversion; busy=0 in the next cycle.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits above the ones digit are blanked. The ones digit always shows. The minus sign moves to the digit immediately left of the most significant nonzero digit.
- Undefined: all DIGITS digits show, including leading zeros; the minus sign sits in the most significant digit.

Test Plan:
- Defaults. bin=25, save; bin=17, op=00, exec -> after 21 busy cycles digits read 0042, neg=0, overflow=0.
- Negative subtract. A=5, B=12, op=01 -> digits read -007, neg=1. With LEADING_ZERO_BLANK_EN: blank, blank, -, 7.
- Multiply overflow. A=1023, B=1023, op=10 -> result 1046529, overflow=1, all four digits show dash.
- Bounce rejection. btn_save toggles every 100 cycles for 2000 cycles, then stays high -> exactly one save pulse; A equals bin only after DEBOUNCE_CYCLES of stable high.
- Simultaneous events and reset.
  - save and exec pulse in the same cycle -> A reloaded, state HAVE_A, no result computed.
  - rst asserted at cycle 5 of a conversion -> busy=0 next cycle, an all 1, digits 0.
- Scan. REFRESH_DIV=4, DIGITS=4 -> an sequence 1110, 1101, 1011, 0111, 1110 with each value held 4 cycles.

Source files
------------

// File: rtl/multi_op_calculator.sv
`default_nettype none
// ============================================================================
//  Module   : multi_op_calculator
//  Brief    : Switch-operand calculator (add / subtract / multiply / clear)
//             with debounced buttons, sequential shift-add-3 binary-to-BCD
//             conversion, sign/overflow handling and a multiplexed
//             active-low 7-segment display.
//  Options  : LEADING_ZERO_BLANK_EN - blank leading zeros and float the
//             minus sign next to the most significant nonzero digit.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_op_calculator #(
  parameter int WIDTH           = 10,
  parameter int DIGITS          = 4,
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  bin,
  input  logic              btn_save,
  input  logic              btn_exec,
  input  logic [1:0]        op_sel,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic [WIDTH-1:0]  led,
  output logic              busy,
  output logic              overflow,
  output logic              neg
);

  // Result width and the BCD digit count needed to hold any RW-bit value
  // (3 bits per decimal digit is always sufficient).
  localparam int C_RW      = 2 * WIDTH;
  localparam int C_ND_MIN  = (C_RW + 2) / 3;
  localparam int C_NBCD    = (C_ND_MIN > DIGITS) ? C_ND_MIN : DIGITS;
  localparam int C_CW      = $clog2(C_RW + 1);
  localparam int C_DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int C_RDW     = $clog2(REFRESH_DIV + 1);
  localparam int C_SIW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Internal digit codes: 0-9 are decimal, the rest are glyph selectors.
  localparam logic [3:0] C_DASH  = 4'hA;
  localparam logic [3:0] C_BLANK = 4'hF;

  // --------------------------------------------------------------------------
  // Button conditioning
  // --------------------------------------------------------------------------
  logic [1:0] w_btn_raw;
  logic [1:0] w_pulse;
  logic       w_save;
  logic       w_exec;

  assign w_btn_raw = {btn_exec, btn_save};

  for (genvar gb = 0; gb < 2; gb++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_prev_q;
    logic [C_DBW-1:0] cnt_q;

    // Synchronise, accept a new level only after it has been stable, then edge-detect
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
        cnt_q        <= '0;
      end else begin
        sync1_q      <= w_btn_raw[gb];
        sync2_q      <= sync1_q;
        level_prev_q <= level_q;
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == C_DBW'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + C_DBW'(1);
        end
      end
    end

    assign w_pulse[gb] = level_q & ~level_prev_q;
  end

  assign w_save = w_pulse[0];
  assign w_exec = w_pulse[1];

  // --------------------------------------------------------------------------
  // Operand / result state machine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HAVE_A   = 2'd1,
    S_SHOW_RES = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [C_RW-1:0]   result_q;
  logic              neg_q;

  logic [C_RW-1:0]   w_a_ext;
  logic [C_RW-1:0]   w_b_ext;
  logic              w_b_gt_a;
  logic [C_RW-1:0]   w_sum;
  logic [C_RW-1:0]   w_diff;
  logic [C_RW-1:0]   w_prod;

  assign w_a_ext  = {{WIDTH{1'b0}}, a_q};
  assign w_b_ext  = {{WIDTH{1'b0}}, bin};
  assign w_b_gt_a = (bin > a_q);
  assign w_sum    = w_a_ext + w_b_ext;
  assign w_diff   = w_b_gt_a ? (w_b_ext - w_a_ext) : (w_a_ext - w_b_ext);
  assign w_prod   = w_a_ext * w_b_ext;

  // Save beats exec when both pulse together; exec is ignored until A exists
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
    end else if (w_save) begin
      a_q     <= bin;
      state_q <= S_HAVE_A;
    end else if (w_exec && (state_q != S_IDLE)) begin
      case (op_sel)
        2'b00: begin
          result_q <= w_sum;
          neg_q    <= 1'b0;
          state_q  <= S_SHOW_RES;
        end
        2'b01: begin
          result_q <= w_diff;
          neg_q    <= w_b_gt_a;
          state_q  <= S_SHOW_RES;
        end
        2'b10: begin
          result_q <= w_prod;
          neg_q    <= 1'b0;
          state_q  <= S_SHOW_RES;
        end
        default: begin
          result_q <= '0;
          neg_q    <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  // Value presented to the converter: the result when showing one, else the switches
  logic [C_RW-1:0] w_disp_val;
  logic            w_disp_neg;

  assign w_disp_val = (state_q == S_SHOW_RES) ? result_q : w_b_ext;
  assign w_disp_neg = (state_q == S_SHOW_RES) && neg_q;

  // --------------------------------------------------------------------------
  // Sequential binary-to-BCD converter (shift-add-3)
  // --------------------------------------------------------------------------
  logic                  busy_q;
  logic [C_CW-1:0]       cnt_q;
  logic [C_RW-1:0]       val_q;
  logic                  vneg_q;
  logic [C_RW-1:0]       last_val_q;
  logic                  last_neg_q;
  logic [C_RW-1:0]       sh_q;
  logic [4*C_NBCD-1:0]   bcd_q;
  logic [3:0]            codes_q [DIGITS];
  logic                  ovf_q;

  logic [4*C_NBCD-1:0]   w_bcd_adj;
  logic [4*C_NBCD-1:0]   w_bcd_next;
  logic [C_RW-1:0]       w_sh_next;

  for (genvar gd = 0; gd < C_NBCD; gd++) begin : g_adj
    assign w_bcd_adj[4*gd +: 4] = (bcd_q[4*gd +: 4] >= 4'd5) ?
                                  (bcd_q[4*gd +: 4] + 4'd3) : bcd_q[4*gd +: 4];
  end

  assign {w_bcd_next, w_sh_next} = {w_bcd_adj, sh_q} << 1;

  // Final digit codes, sign placement and overflow from the completed BCD word
  logic       w_hi_nz;
  logic       w_sign_ovf;
  logic       w_ovf;
  int         w_msd;
  logic [3:0] w_codes [DIGITS];

  // Derive displayed glyph codes and overflow for the value just converted
  always_comb begin
    w_hi_nz    = 1'b0;
    w_msd      = 0;
    w_sign_ovf = 1'b0;
    w_ovf      = 1'b0;
    for (int i = 0; i < C_NBCD; i++) begin
      if (w_bcd_next[4*i +: 4] != 4'd0) begin
        if (i >= DIGITS) w_hi_nz = 1'b1;
        else             w_msd   = i;
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      w_codes[i] = w_bcd_next[4*i +: 4];
    end
`ifdef LEADING_ZERO_BLANK_EN
    // Ones digit is never blanked because w_msd is at least 0.
    for (int i = 0; i < DIGITS; i++) begin
      if (i > w_msd) w_codes[i] = C_BLANK;
    end
    w_sign_ovf = vneg_q && ((w_msd + 1) >= DIGITS);
    if (vneg_q && !w_sign_ovf) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (i == w_msd + 1) w_codes[i] = C_DASH;
      end
    end
`else
    w_sign_ovf = vneg_q && (w_bcd_next[4*(DIGITS-1) +: 4] != 4'd0);
    if (vneg_q) w_codes[DIGITS-1] = C_DASH;
`endif
    w_ovf = w_hi_nz | w_sign_ovf;
    if (w_ovf) begin
      for (int i = 0; i < DIGITS; i++) w_codes[i] = C_DASH;
    end
  end

  // Converter: start on a changed value, load, RW add-3/shift steps, commit digits at the end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      val_q      <= '0;
      vneg_q     <= 1'b0;
      last_val_q <= '0;
      last_neg_q <= 1'b0;
      sh_q       <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < DIGITS; i++) codes_q[i] <= 4'd0;
    end else if (!busy_q) begin
      if ({w_disp_neg, w_disp_val} != {last_neg_q, last_val_q}) begin
        busy_q     <= 1'b1;
        cnt_q      <= '0;
        val_q      <= w_disp_val;
        vneg_q     <= w_disp_neg;
        last_val_q <= w_disp_val;
        last_neg_q <= w_disp_neg;
      end
    end else if (cnt_q == '0) begin
      bcd_q <= '0;
      sh_q  <= val_q;
      cnt_q <= C_CW'(1);
    end else begin
      bcd_q <= w_bcd_next;
      sh_q  <= w_sh_next;
      if (cnt_q == C_CW'(C_RW)) begin
        busy_q <= 1'b0;
        ovf_q  <= w_ovf;
        for (int i = 0; i < DIGITS; i++) codes_q[i] <= w_codes[i];
      end else begin
        cnt_q <= cnt_q + C_CW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Display scan and LED mirror
  // --------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      C_DASH:  seg_decode = 7'b0111111;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  logic [C_RDW-1:0]  div_q;
  logic [C_SIW-1:0]  idx_q;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] an_q;
  logic [WIDTH-1:0]  led_q;

  // Step through digits every REFRESH_DIV cycles; seg and an update together
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      seg_q <= 7'h7F;
      an_q  <= '1;
    end else begin
      if (div_q == C_RDW'(REFRESH_DIV - 1)) begin
        div_q <= '0;
        idx_q <= (idx_q == C_SIW'(DIGITS - 1)) ? '0 : (idx_q + C_SIW'(1));
      end else begin
        div_q <= div_q + C_RDW'(1);
      end
      seg_q <= seg_decode(codes_q[idx_q]);
      an_q  <= ~(DIGITS'(1) << idx_q);
    end
  end

  // Mirror the switches onto the LEDs with one cycle of latency
  always_ff @(posedge clk) begin
    if (rst) led_q <= '0;
    else     led_q <= bin;
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign led      = led_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign neg      = neg_q;

endmodule
`default_nettype wire
